// File: rtl/order_register_decoder_if.sv
// Order register bus: serial order input, clear handshake, and the held
// decode (address, long flag, one-hot function lines).
interface order_register_decoder_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  order_start;
   logic                  order_bit_valid;
   logic                  order_bit;
   logic                  order_clear;
   logic                  order_ready;
   logic                  order_overrun;
   logic [ADDR_WIDTH-1:0] address;
   logic                  long_flag;
   logic op_p, op_q, op_w, op_e, op_r, op_t, op_y, op_u;
   logic op_i, op_o, op_j, op_pi, op_s, op_z, op_k, op_erase;
   logic op_blank, op_f, op_theta, op_d, op_phi, op_h, op_n, op_m;
   logic op_delta, op_l, op_x, op_g, op_a, op_b, op_c, op_v;

   modport master (
      output order_start, order_bit_valid, order_bit, order_clear,
      input  order_ready, order_overrun, address, long_flag,
      input  op_p, op_q, op_w, op_e, op_r, op_t, op_y, op_u,
      input  op_i, op_o, op_j, op_pi, op_s, op_z, op_k, op_erase,
      input  op_blank, op_f, op_theta, op_d, op_phi, op_h, op_n, op_m,
      input  op_delta, op_l, op_x, op_g, op_a, op_b, op_c, op_v
   );

   modport slave (
      input  order_start, order_bit_valid, order_bit, order_clear,
      output order_ready, order_overrun, address, long_flag,
      output op_p, op_q, op_w, op_e, op_r, op_t, op_y, op_u,
      output op_i, op_o, op_j, op_pi, op_s, op_z, op_k, op_erase,
      output op_blank, op_f, op_theta, op_d, op_phi, op_h, op_n, op_m,
      output op_delta, op_l, op_x, op_g, op_a, op_b, op_c, op_v
   );
endinterface

// File: rtl/order_register_decoder.sv
// Serial-in order register and function decoder. Shifts a 17-bit order
// LSB-first, then holds address, long flag and a one-hot function decode
// until the execute phase releases it with order_clear.
module order_register_decoder #(
   parameter int ORDER_BITS = 17,
   parameter int ADDR_WIDTH = 10
) (
   input logic                     clk,
   input logic                     rst_n,
   order_register_decoder_if.slave bus
);
   localparam int CNT_W    = $clog2(ORDER_BITS);
   localparam int FUNC_W   = 5;
   localparam int NUM_OPS  = 1 << FUNC_W;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ORDER_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t                  state_q, state_n;
   logic [CNT_W-1:0]        cnt_q, cnt_n;
   logic [ORDER_BITS-1:0]   sreg_q, sreg_n;
   logic                    ready_q, ready_n;
   logic                    overrun_q, overrun_n;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
   logic                    long_q, long_n;
   logic [NUM_OPS-1:0]      op_q, op_n;

   // State and output registers; everything visible is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sreg_q    <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
         addr_q    <= '0;
         long_q    <= 1'b0;
         op_q      <= '0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         sreg_q    <= sreg_n;
         ready_q   <= ready_n;
         overrun_q <= overrun_n;
         addr_q    <= addr_n;
         long_q    <= long_n;
         op_q      <= op_n;
      end
   end

   // Next-state: shift, restart on order_start, decode on the 17th bit,
   // release on order_clear (which may coincide with a new order's bit 0).
   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      sreg_n    = sreg_q;
      ready_n   = ready_q;
      overrun_n = 1'b0;
      addr_n    = addr_q;
      long_n    = long_q;
      op_n      = op_q;
      unique case (state_q)
         IDLE: begin
            if (bus.order_bit_valid && bus.order_start) begin
               sreg_n    = '0;
               sreg_n[0] = bus.order_bit;
               cnt_n     = CNT_W'(1);
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.order_bit_valid) begin
               if (bus.order_start) begin
                  sreg_n    = '0;
                  sreg_n[0] = bus.order_bit;
                  cnt_n     = CNT_W'(1);
               end else begin
                  sreg_n[cnt_q] = bus.order_bit;
                  if (cnt_q == LAST_BIT) begin
                     state_n = HOLD;
                     cnt_n   = '0;
                     ready_n = 1'b1;
                     addr_n  = sreg_n[ADDR_WIDTH:1];
                     long_n  = sreg_n[0];
                     op_n    = '0;
                     op_n[sreg_n[ORDER_BITS-1 -: FUNC_W]] = 1'b1;
                  end else begin
                     cnt_n = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         HOLD: begin
            if (bus.order_clear) begin
               state_n = IDLE;
               ready_n = 1'b0;
               op_n    = '0;
               if (bus.order_bit_valid && bus.order_start) begin
                  sreg_n    = '0;
                  sreg_n[0] = bus.order_bit;
                  cnt_n     = CNT_W'(1);
                  state_n   = SHIFT;
               end
            end else if (bus.order_bit_valid) begin
               overrun_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.order_ready   = ready_q;
   assign bus.order_overrun = overrun_q;
   assign bus.address       = addr_q;
   assign bus.long_flag     = long_q;

   assign bus.op_p     = op_q[0];
   assign bus.op_q     = op_q[1];
   assign bus.op_w     = op_q[2];
   assign bus.op_e     = op_q[3];
   assign bus.op_r     = op_q[4];
   assign bus.op_t     = op_q[5];
   assign bus.op_y     = op_q[6];
   assign bus.op_u     = op_q[7];
   assign bus.op_i     = op_q[8];
   assign bus.op_o     = op_q[9];
   assign bus.op_j     = op_q[10];
   assign bus.op_pi    = op_q[11];
   assign bus.op_s     = op_q[12];
   assign bus.op_z     = op_q[13];
   assign bus.op_k     = op_q[14];
   assign bus.op_erase = op_q[15];
   assign bus.op_blank = op_q[16];
   assign bus.op_f     = op_q[17];
   assign bus.op_theta = op_q[18];
   assign bus.op_d     = op_q[19];
   assign bus.op_phi   = op_q[20];
   assign bus.op_h     = op_q[21];
   assign bus.op_n     = op_q[22];
   assign bus.op_m     = op_q[23];
   assign bus.op_delta = op_q[24];
   assign bus.op_l     = op_q[25];
   assign bus.op_x     = op_q[26];
   assign bus.op_g     = op_q[27];
   assign bus.op_a     = op_q[28];
   assign bus.op_b     = op_q[29];
   assign bus.op_c     = op_q[30];
   assign bus.op_v     = op_q[31];
endmodule

// File: tb/tb_order_register_decoder.sv
// Bench for order_register_decoder: table of named orders, hand-written
// abort/overrun/clear/reset sequences, and random traffic checked every
// cycle against a queue-based reference model.
module tb_order_register_decoder;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   order_register_decoder_if #(.ADDR_WIDTH(10)) bus ();

   order_register_decoder #(.ORDER_BITS(17), .ADDR_WIDTH(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Function lines gathered in port-list order: bit i is function code i.
   logic [31:0] ops_v;
   assign ops_v = {bus.op_v, bus.op_c, bus.op_b, bus.op_a, bus.op_g, bus.op_x,
                   bus.op_l, bus.op_delta, bus.op_m, bus.op_n, bus.op_h,
                   bus.op_phi, bus.op_d, bus.op_theta, bus.op_f, bus.op_blank,
                   bus.op_erase, bus.op_k, bus.op_z, bus.op_s, bus.op_pi,
                   bus.op_j, bus.op_o, bus.op_i, bus.op_u, bus.op_y, bus.op_t,
                   bus.op_r, bus.op_e, bus.op_w, bus.op_q, bus.op_p};

   // Reference model: collects strobed bits in a queue, evaluates the word
   // arithmetically once 17 bits are in.
   bit          m_bits[$];
   bit          m_collecting = 1'b0;
   bit          m_holding    = 1'b0;
   logic        m_ready      = 1'b0;
   logic        m_overrun    = 1'b0;
   logic [9:0]  m_addr       = '0;
   logic        m_long       = 1'b0;
   logic [31:0] m_ops        = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits.delete();
         m_collecting = 1'b0;
         m_holding    = 1'b0;
         m_ready      = 1'b0;
         m_overrun    = 1'b0;
         m_addr       = '0;
         m_long       = 1'b0;
         m_ops        = '0;
      end else begin
         m_overrun = 1'b0;
         if (m_holding) begin
            if (bus.order_clear) begin
               m_holding = 1'b0;
               m_ready   = 1'b0;
               m_ops     = '0;
               if (bus.order_bit_valid && bus.order_start) begin
                  m_bits.delete();
                  m_bits.push_back(bus.order_bit);
                  m_collecting = 1'b1;
               end
            end else if (bus.order_bit_valid) begin
               m_overrun = 1'b1;
            end
         end else if (bus.order_bit_valid) begin
            if (bus.order_start) begin
               m_bits.delete();
               m_bits.push_back(bus.order_bit);
               m_collecting = 1'b1;
            end else if (m_collecting) begin
               m_bits.push_back(bus.order_bit);
               if (m_bits.size() == 17) begin
                  int unsigned word;
                  word = 0;
                  for (int i = 0; i < 17; i++) word += int'(m_bits[i]) << i;
                  m_long       = word[0];
                  m_addr       = 10'((word / 2) % 1024);
                  m_ops        = 32'd1 << (word / 4096);
                  m_ready      = 1'b1;
                  m_holding    = 1'b1;
                  m_collecting = 1'b0;
                  m_bits.delete();
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".ready"},   32'(bus.order_ready),   32'(m_ready));
      chk({tag, ".overrun"}, 32'(bus.order_overrun), 32'(m_overrun));
      chk({tag, ".address"}, 32'(bus.address),       32'(m_addr));
      chk({tag, ".long"},    32'(bus.long_flag),     32'(m_long));
      chk({tag, ".ops"},     ops_v,                  m_ops);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".ready"},   32'(bus.order_ready),   32'd0);
      chk({tag, ".overrun"}, 32'(bus.order_overrun), 32'd0);
      chk({tag, ".address"}, 32'(bus.address),       32'd0);
      chk({tag, ".long"},    32'(bus.long_flag),     32'd0);
      chk({tag, ".ops"},     ops_v,                  32'd0);
   endtask

   // One cycle of stimulus, driven after a falling edge and checked at the next.
   task automatic apply(input logic v, input logic b, input logic s, input logic c);
      bus.order_bit_valid = v;
      bus.order_bit       = b;
      bus.order_start     = s;
      bus.order_clear     = c;
      @(negedge clk);
      bus.order_bit_valid = 1'b0;
      bus.order_bit       = 1'b0;
      bus.order_start     = 1'b0;
      bus.order_clear     = 1'b0;
      check_model("cyc");
   endtask

   // Strobe bits [first, nbits) of w; gap < 0 picks 0..3 idle cycles per bit.
   task automatic send_order(input logic [16:0] w, input int first, input int nbits, input int gap);
      for (int i = first; i < nbits; i++) begin
         apply(1'b1, w[i], i == 0, 1'b0);
         if (i != nbits - 1) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(3)) : gap;
            repeat (g) apply(1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   function automatic logic [16:0] mk(input logic [4:0] fn, input logic [9:0] addr, input logic l);
      return {fn, 1'b0, addr, l};
   endfunction

   typedef struct {
      string      name;
      logic [4:0] fn;
      logic [9:0] addr;
      logic       l;
      int         gap;
      int         exp_op;
   } order_vec_t;

   order_vec_t tbl[$];

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      bus.order_start = 1'b0; bus.order_bit_valid = 1'b0;
      bus.order_bit   = 1'b0; bus.order_clear     = 1'b0;

      // Named orders with hand-derived expected function line.
      tbl.push_back('{"A_100_S", 5'd28, 10'd100, 1'b0, 0, 28});
      tbl.push_back('{"T_5_L",   5'd5,  10'd5,   1'b1, 2, 5});
      tbl.push_back('{"P_1023",  5'd0,  10'd1023,1'b0, 3, 0});
      tbl.push_back('{"V_512_L", 5'd31, 10'd512, 1'b1, 1, 31});
      tbl.push_back('{"E_77",    5'd3,  10'd77,  1'b1, -1, 3});

      @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      apply(1'b1, 1'b1, 1'b0, 1'b0);   // strobe without start in IDLE: ignored
      apply(1'b0, 1'b0, 1'b0, 1'b1);   // clear in IDLE: ignored
      check_reset("idle_ignore");

      // Table-driven named orders.
      foreach (tbl[k]) begin
         logic [16:0] w;
         w = mk(tbl[k].fn, tbl[k].addr, tbl[k].l);
         send_order(w, 0, 16, tbl[k].gap);
         chk({tbl[k].name, ".not_ready_16"}, 32'(bus.order_ready), 32'd0);
         repeat (tbl[k].gap < 0 ? 1 : tbl[k].gap) apply(1'b0, 1'b0, 1'b0, 1'b0);
         apply(1'b1, w[16], 1'b0, 1'b0);
         chk({tbl[k].name, ".ready"},   32'(bus.order_ready), 32'd1);
         chk({tbl[k].name, ".op"},      ops_v, 32'd1 << tbl[k].exp_op);
         chk({tbl[k].name, ".address"}, 32'(bus.address), 32'(tbl[k].addr));
         chk({tbl[k].name, ".long"},    32'(bus.long_flag), 32'(tbl[k].l));
         apply(1'b0, 1'b0, 1'b0, 1'b1);
         chk({tbl[k].name, ".cleared"}, 32'(bus.order_ready), 32'd0);
         chk({tbl[k].name, ".ops_off"}, ops_v, 32'd0);
         chk({tbl[k].name, ".addr_kept"}, 32'(bus.address), 32'(tbl[k].addr));
      end

      // Sweep every function code, address 0, long flag set.
      for (int fn = 0; fn < 32; fn++) begin
         send_order(mk(5'(fn), 10'd0, 1'b1), 0, 17, 0);
         chk("sweep.op", ops_v, 32'd1 << fn);
         chk("sweep.popcount", 32'($countones(ops_v)), 32'd1);
         chk("sweep.long", 32'(bus.long_flag), 32'd1);
         apply(1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Abort after 9 bits, then a full "T 5 L"; the aborted order never decodes.
      send_order(mk(5'd28, 10'd100, 1'b0), 0, 9, 0);
      chk("abort.not_ready", 32'(bus.order_ready), 32'd0);
      send_order(mk(5'd5, 10'd5, 1'b1), 0, 17, 1);
      chk("abort.op_t", 32'(bus.op_t), 32'd1);
      chk("abort.ops", ops_v, 32'h0000_0020);
      chk("abort.address", 32'(bus.address), 32'd5);

      // Overrun in HOLD: one-cycle pulse, decode unchanged; then clear.
      apply(1'b1, 1'b1, 1'b0, 1'b0);
      chk("overrun.pulse", 32'(bus.order_overrun), 32'd1);
      chk("overrun.ops_held", ops_v, 32'h0000_0020);
      chk("overrun.addr_held", 32'(bus.address), 32'd5);
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      chk("overrun.one_cycle", 32'(bus.order_overrun), 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      chk("overrun.clear_ready", 32'(bus.order_ready), 32'd0);
      chk("overrun.clear_ops", ops_v, 32'd0);

      // Clear coinciding with bit 0 of the next order.
      send_order(mk(5'd12, 10'd300, 1'b0), 0, 17, 0);
      begin
         logic [16:0] w2;
         w2 = mk(5'd19, 10'd42, 1'b1);
         apply(1'b1, w2[0], 1'b1, 1'b1);
         chk("clr_start.no_overrun", 32'(bus.order_overrun), 32'd0);
         chk("clr_start.ready_off", 32'(bus.order_ready), 32'd0);
         send_order(w2, 1, 17, 0);
         chk("clr_start.op_d", ops_v, 32'd1 << 19);
         chk("clr_start.address", 32'(bus.address), 32'd42);
         apply(1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Reset pulse at bit 12, and again while holding.
      send_order(mk(5'd7, 10'd999, 1'b1), 0, 12, 0);
      rst_n = 1'b0;
      #1 check_reset("rst_shift");
      @(negedge clk) rst_n = 1'b1;
      send_order(mk(5'd9, 10'd321, 1'b1), 0, 17, 0);
      rst_n = 1'b0;
      #1 check_reset("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      send_order(mk(5'd28, 10'd100, 1'b0), 0, 17, 0);
      chk("after_rst.op_a", 32'(bus.op_a), 32'd1);
      chk("after_rst.address", 32'(bus.address), 32'd100);
      apply(1'b0, 1'b0, 1'b0, 1'b1);

      // Random whole orders with random gaps, overruns and clears.
      for (int n = 0; n < 40; n++) begin
         send_order(17'($urandom), 0, 17, -1);
         if ($urandom_range(2) == 0) apply(1'b1, 1'($urandom), 1'b0, 1'b0);
         apply(1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Random per-cycle traffic.
      for (int n = 0; n < 3000; n++) begin
         apply($urandom_range(1) == 1, 1'($urandom),
               $urandom_range(19) == 0, $urandom_range(7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
